// File: rtl/countdown_key_ctrl_if.sv
// countdown_key_ctrl_if: raw keys and running flag in, command pulses and repeat owner out.
interface countdown_key_ctrl_if;
  logic       key_start_n;
  logic       key_reset_n;
  logic       key_add_n;
  logic       key_sub_n;
  logic       running;
  logic       start_pause_p;
  logic       reset_p;
  logic       add_p;
  logic       sub_p;
  logic [1:0] adj_owner;
  modport master (
    output key_start_n, key_reset_n, key_add_n, key_sub_n, running,
    input  start_pause_p, reset_p, add_p, sub_p, adj_owner
  );
  modport slave (
    input  key_start_n, key_reset_n, key_add_n, key_sub_n, running,
    output start_pause_p, reset_p, add_p, sub_p, adj_owner
  );
endinterface

// File: rtl/countdown_key_ctrl.sv
// countdown_key_ctrl: debounces four push-buttons into prioritised one-cycle commands,
// with a shared auto-repeat engine for the +1/-1 keys.
module countdown_key_ctrl #(
  parameter int DEB_CYCLES    = 200_000,
  parameter int HOLD_CYCLES   = 5_000_000,
  parameter int REPEAT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  countdown_key_ctrl_if.slave kb
);
  localparam logic [23:0] DEB_LAST = 24'(DEB_CYCLES - 1);
  localparam logic [23:0] HOLD_LD  = 24'(HOLD_CYCLES);
  localparam logic [23:0] REP_LD   = 24'(REPEAT_CYCLES);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [23:0]      tmr_q, tmr_d;
  logic [3:0]       raw, sync1_q, sync2_q, stable_q, flip, press;
  logic [1:0]       rel_as;
  logic [3:0][23:0] cnt_q, cnt_d;
  logic             req, rst_ev, st_ev, adj_ok, own_rel;
  logic             start_q, reset_q, add_q, sub_q;
  // key index: 0 start/pause, 1 reset, 2 add, 3 sub
  assign raw = {kb.key_sub_n, kb.key_add_n, kb.key_reset_n, kb.key_start_n};
  for (genvar k = 0; k < 4; k++) begin : g_deb
    assign flip[k]  = (sync2_q[k] != stable_q[k]) && (cnt_q[k] == DEB_LAST);
    assign cnt_d[k] = (sync2_q[k] == stable_q[k] || flip[k]) ? '0 : cnt_q[k] + 24'd1;
  end
  assign press   = flip & stable_q;
  assign rel_as  = flip[3:2] & ~stable_q[3:2];
  assign rst_ev  = press[1];
  assign st_ev   = press[0] & ~rst_ev;
  assign own_rel = (owner_q == 2'd1) ? rel_as[0] : rel_as[1];
  // losing or gated add/sub requests are simply dropped; the engine timing is untouched
  assign adj_ok  = req & ~rst_ev & ~st_ev & ~kb.running;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tmr_d   = tmr_q;
    req     = 1'b0;
    if (rst_ev) begin
      state_d = IDLE;
      owner_d = 2'd0;
      tmr_d   = '0;
    end else if (state_q == IDLE) begin
      if (press[2] | press[3]) begin
        state_d = HOLD;
        owner_d = press[2] ? 2'd1 : 2'd2;
        tmr_d   = HOLD_LD;
        req     = 1'b1;
      end
    end else if (own_rel) begin
      state_d = IDLE;
      owner_d = 2'd0;
      tmr_d   = '0;
    end else if (tmr_q == 24'd1) begin
      state_d = REPEAT;
      tmr_d   = REP_LD;
      req     = 1'b1;
    end else begin
      tmr_d = tmr_q - 24'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      cnt_q    <= '0;
      state_q  <= IDLE;
      owner_q  <= '0;
      tmr_q    <= '0;
      start_q  <= 1'b0;
      reset_q  <= 1'b0;
      add_q    <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_q ^ flip;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      owner_q  <= owner_d;
      tmr_q    <= tmr_d;
      start_q  <= st_ev;
      reset_q  <= rst_ev;
      add_q    <= adj_ok & (owner_d == 2'd1);
      sub_q    <= adj_ok & (owner_d == 2'd2);
    end
  end
  assign kb.start_pause_p = start_q;
  assign kb.reset_p       = reset_q;
  assign kb.add_p         = add_q;
  assign kb.sub_p         = sub_q;
  assign kb.adj_owner     = owner_q;
endmodule

// File: doc/countdown_key_ctrl.md
# countdown_key_ctrl

Front-end key controller for the ≤60 s countdown timer. It synchronises and debounces the four raw push-buttons (start/pause, reset, +1 s, −1 s) and arbitrates them into single-cycle command pulses with fixed priority. Holding +1/−1 auto-repeats those pulses. The block drives the pulse inputs of the countdown state machine directly and uses that machine's `running` flag to gate time adjustment.

## Interface
Parameters:
- `DEB_CYCLES`, 200_000: consecutive stable cycles needed to accept a key change (20 ms at 10 MHz); ≥2.
- `HOLD_CYCLES`, 5_000_000: cycles from first add/sub pulse to first repeat pulse (500 ms); ≥2.
- `REPEAT_CYCLES`, 1_000_000: cycles between repeat pulses (100 ms); ≥2.
- All counters are 24 bit. Every parameter must be < 2^24.

Ports:
- `clk`  in  1: system clock (10 MHz nominal).
- `rst_n`  in  1: reset, asynchronous, active-low.
- `key_start_n`  in  1: raw start/pause button, active-low, asynchronous to `clk`.
- `key_reset_n`  in  1: raw reset button, active-low, asynchronous.
- `key_add_n`  in  1: raw +1 s button, active-low, asynchronous.
- `key_sub_n`  in  1: raw −1 s button, active-low, asynchronous.
- `running`  in  1: from the countdown FSM; 1 = counting.
- `start_pause_p`  out  1: one-cycle start/pause command.
- `reset_p`  out  1: one-cycle reset command.
- `add_p`  out  1: one-cycle +1 s command.
- `sub_p`  out  1: one-cycle −1 s command.
- `adj_owner`  out  2: current owner of the repeat engine: 0 = none, 1 = add, 2 = sub.

## Operation
- Synchroniser: two flip-flops per key. Reset value is 1 (released).
- Debounce, per key:
  - The stable level resets to released.
  - A counter increments while the synced level differs from the stable level. It clears to 0 on any cycle where they match.
  - When the counter would reach `DEB_CYCLES`, the stable level flips and the counter clears.
  - A press event is a stable transition from released to pressed. Release events are used only by the repeat engine.
- Start and reset keys: each press event produces exactly one pulse. Holding the key does not repeat.
- Repeat engine: one shared engine for add and sub, with states IDLE, HOLD and REPEAT.
  - IDLE: on an add or sub press event, take ownership, request one pulse, load the timer with `HOLD_CYCLES`, and go to HOLD.
  - If add and sub press events occur in the same cycle, add wins and the sub press is discarded.
  - HOLD: the timer decrements. When it expires, request a pulse, load `REPEAT_CYCLES`, and go to REPEAT.
  - REPEAT: request a pulse and reload every `REPEAT_CYCLES` cycles.
  - Owner release event, from HOLD or REPEAT: go to IDLE and set owner to none. No pulse is produced in the release cycle.
  - A press event of the non-owner key while the engine is owned is discarded. Once discarded, that key stays ignored until it is released and pressed again.
- Output arbitration: at most one output pulse per cycle.
  - Priority order: reset > start/pause > add/sub.
  - A lower-priority request that loses arbitration is dropped, not queued. Repeat timing continues unaffected.
  - A reset press event also forces the repeat engine to IDLE with owner none. A held add/sub key must be re-pressed to take effect again.
- Gating: while `running`=1, add/sub requests are dropped. The engine still tracks state and ownership.
- All outputs are registered.

## Timing
- Reset values: all pulse outputs 0, `adj_owner`=0, engine IDLE, all counters 0, synced and stable levels released.
- Press latency: a key low from clock edge E with no bounce gives a pulse high for exactly the one cycle after edge E+DEB_CYCLES+2. That is 2 cycles of synchroniser, DEB_CYCLES of debounce, and 1 output register.
- Release latency is the same path. The engine enters IDLE on the edge at which the stable level returns to released.
- Repeat spacing, measured at the outputs:
  - pulse 1 to pulse 2: exactly `HOLD_CYCLES` cycles.
  - each later pulse: exactly `REPEAT_CYCLES` cycles apart.
- Bounce: a glitch shorter than `DEB_CYCLES` cycles in the synced domain produces no event and restarts the count.
- `rst_n` asserted mid-operation clears everything immediately.
  - A key still held when `rst_n` deasserts is seen as a fresh press.
  - Its pulse appears DEB_CYCLES+2 edges after reset release.
- `running` is sampled in the cycle the request is arbitrated. There is no pipeline skew with respect to that request.

## Test plan
Use DEB_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5 unless stated.
- Clean press: `key_start_n` low from edge 10 and held 100 cycles -> `start_pause_p` high only in the one cycle after edge 16. No further pulse is produced; release produces no pulse.
- Bounce: `key_add_n` toggles every 2 cycles for 20 cycles, then stays low -> no pulse during the bounce. Exactly one `add_p` appears 6 edges after the final falling edge.
- Auto-repeat: `key_sub_n` held 60 cycles with `running`=0 -> `sub_p` pulses at offsets 0, 20, 25, 30, 35, … relative to the first pulse, ending after the release event. `adj_owner`=2 throughout.
- Simultaneous: add and sub pressed on the same edge -> only `add_p` pulses and `adj_owner`=1. After add is released with sub still held, no `sub_p` is produced until sub is released and pressed again.
- Priority and gating: reset and start press events arbitrated in the same cycle -> `reset_p` only; engine IDLE. `key_add_n` held with `running`=1 -> no `add_p`, `adj_owner`=1. Dropping `running` to 0 -> the next repeat slot produces `add_p`.
- Async reset: pulse `rst_n` low for 3 cycles while in REPEAT with add held -> all outputs 0 immediately. The first `add_p` appears 6 edges after `rst_n` returns high.
